// File: rtl/usb_if_pkg.sv
// usb_if_pkg
//   Shared definitions for the USB slave-FIFO writer slice: the data word
//   width, the default idle gap after a packet-end strobe, and the state
//   encoding of the writer FSM.
// Ports: none (package).
package usb_if_pkg;

  localparam int WORD_WIDTH         = 16;
  localparam int DEFAULT_PKTEND_GAP = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WRITE      = 3'd1,
    ST_FLUSH_WAIT = 3'd2,
    ST_PKTEND     = 3'd3,
    ST_GAP        = 3'd4,
    ST_DONE       = 3'd5
  } usb_state_e;

endpackage

// File: rtl/usb_tx_fifo.sv
// usb_tx_fifo
//   Single-clock synchronous FIFO with a first-word-fall-through head: the
//   oldest word is always visible on rd_data while empty is low, and rd_en
//   pops it at the next edge. Writes while full and reads while empty are
//   ignored.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (pointers/count only)
//   wr_en/wr_data - push request and word
//   rd_en/rd_data - pop request and head word
//   full, empty   - occupancy flags
//   count         - number of stored words, 0 .. 2**ADDR_WIDTH
module usb_tx_fifo
  import usb_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array carries no reset so it can map onto RAM; stale contents
  // are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/usb_slave_fifo_writer.sv
// usb_slave_fifo_writer
//   Buffers the non-backpressured DAQ word stream and drains it into the
//   USB controller's synchronous slave FIFO under the FULL flag. A flush
//   request drains the buffer and commits the packet with a PKTEND strobe,
//   followed by an enforced idle gap and a FlushDone pulse.
// Ports:
//   Clk, reset_n          - clock, asynchronous active-low reset
//   DaqData/DaqDataEnable - incoming word and its one-cycle strobe
//   FlushRequest          - pulse: drain and commit the current packet
//   ClearOverflow         - pulse: clear the sticky Overflow flag
//   USB_FULL_N            - USB FIFO full flag (low = full)
//   USB_FD/USB_SLWR_N/USB_PKTEND_N - registered USB FIFO interface
//   BufferEmpty, FillLevel - internal buffer status
//   Overflow              - sticky: a word was dropped on a full buffer
//   FlushDone             - pulse when a flush has completed
//   WordsSent             - words written to USB, wraps at 2**32
module usb_slave_fifo_writer
  import usb_if_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int PKTEND_GAP = DEFAULT_PKTEND_GAP,
  parameter bit ALLOW_ZLP  = 1'b0
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  input  logic [WORD_WIDTH-1:0] DaqData,
  input  logic                  DaqDataEnable,
  input  logic                  FlushRequest,
  input  logic                  ClearOverflow,
  input  logic                  USB_FULL_N,
  output logic [WORD_WIDTH-1:0] USB_FD,
  output logic                  USB_SLWR_N,
  output logic                  USB_PKTEND_N,
  output logic                  BufferEmpty,
  output logic [ADDR_WIDTH:0]   FillLevel,
  output logic                  Overflow,
  output logic                  FlushDone,
  output logic [31:0]           WordsSent
);

  localparam logic [15:0] GAP_ONE  = 16'd1;
  localparam logic [15:0] GAP_LAST = 16'((PKTEND_GAP > 0) ? (PKTEND_GAP - 1) : 0);
  localparam logic [31:0] WS_ONE   = 32'd1;

  usb_state_e            state_q, state_d;
  logic                  flush_pending_q, flush_pending_d;
  logic                  sent_since_pktend_q, sent_since_pktend_d;
  logic [15:0]           gap_cnt_q, gap_cnt_d;
  logic [WORD_WIDTH-1:0] fd_q, fd_d;
  logic                  slwr_n_q, slwr_n_d;
  logic                  pktend_n_q, pktend_n_d;
  logic                  flush_done_q, flush_done_d;
  logic                  overflow_q, overflow_d;
  logic [31:0]           words_sent_q, words_sent_d;

  logic [WORD_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ADDR_WIDTH:0]   fifo_count;
  logic                  issue;
  logic                  drop;

  usb_tx_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (reset_n),
    .wr_en   (DaqDataEnable),
    .wr_data (DaqData),
    .rd_en   (issue),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // A word goes out only in WRITE with data available and room upstream;
  // the same condition pops the buffer so head and strobe stay in lockstep.
  assign issue = (state_q == ST_WRITE) && !fifo_empty && USB_FULL_N;
  assign drop  = DaqDataEnable && fifo_full;

  always_comb begin
    state_d             = state_q;
    gap_cnt_d           = gap_cnt_q;
    pktend_n_d          = 1'b1;
    flush_done_d        = 1'b0;
    flush_pending_d     = flush_pending_q || FlushRequest;
    sent_since_pktend_d = sent_since_pktend_q || issue;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty || flush_pending_q) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (fifo_empty) state_d = flush_pending_q ? ST_FLUSH_WAIT : ST_IDLE;
      end
      ST_FLUSH_WAIT: begin
        // Without any word since the last PKTEND a commit would be a
        // zero-length packet, which is only wanted when explicitly enabled.
        state_d = (sent_since_pktend_q || ALLOW_ZLP) ? ST_PKTEND : ST_DONE;
      end
      ST_PKTEND: begin
        if (USB_FULL_N) begin
          pktend_n_d          = 1'b0;
          sent_since_pktend_d = 1'b0;
          gap_cnt_d           = '0;
          state_d             = (PKTEND_GAP > 0) ? ST_GAP : ST_DONE;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_DONE;
        else                       gap_cnt_d = gap_cnt_q + GAP_ONE;
      end
      ST_DONE: begin
        // A request landing in this very cycle starts a fresh flush.
        flush_done_d    = 1'b1;
        flush_pending_d = FlushRequest;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write datapath, word counter and sticky overflow (set beats clear).
  always_comb begin
    fd_d         = issue ? fifo_head : fd_q;
    slwr_n_d     = !issue;
    words_sent_d = issue ? (words_sent_q + WS_ONE) : words_sent_q;
    overflow_d   = overflow_q;
    if (drop)               overflow_d = 1'b1;
    else if (ClearOverflow) overflow_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q             <= ST_IDLE;
      flush_pending_q     <= 1'b0;
      sent_since_pktend_q <= 1'b0;
      gap_cnt_q           <= '0;
      fd_q                <= '0;
      slwr_n_q            <= 1'b1;
      pktend_n_q          <= 1'b1;
      flush_done_q        <= 1'b0;
      overflow_q          <= 1'b0;
      words_sent_q        <= '0;
    end else begin
      state_q             <= state_d;
      flush_pending_q     <= flush_pending_d;
      sent_since_pktend_q <= sent_since_pktend_d;
      gap_cnt_q           <= gap_cnt_d;
      fd_q                <= fd_d;
      slwr_n_q            <= slwr_n_d;
      pktend_n_q          <= pktend_n_d;
      flush_done_q        <= flush_done_d;
      overflow_q          <= overflow_d;
      words_sent_q        <= words_sent_d;
    end
  end

  assign USB_FD       = fd_q;
  assign USB_SLWR_N   = slwr_n_q;
  assign USB_PKTEND_N = pktend_n_q;
  assign BufferEmpty  = fifo_empty;
  assign FillLevel    = fifo_count;
  assign Overflow     = overflow_q;
  assign FlushDone    = flush_done_q;
  assign WordsSent    = words_sent_q;

endmodule

// File: doc/usb_slave_fifo_writer.md
Name: usb_slave_fifo_writer

Overview:
- Downstream stage of the Microroc DAQ path; sits between the 16-bit DAQ data stream (data + enable strobe) and the USB controller's synchronous slave FIFO.
- Buffers the non-backpressured DAQ words and drains them to the USB FIFO under the FULL flag.
- Issues packet-end on a flush request so short packets reach the host, and reports overflow, fill level and word count.

Parameters:
- ADDR_WIDTH, 10, log2 of internal buffer depth (1024 words).
- PKTEND_GAP, 4, idle Clk cycles enforced after USB_PKTEND_N before the next write.
- ALLOW_ZLP, 0, 1 = issue PKTEND even when no word was written since the last PKTEND.

Ports:
- Clk  in  1  system clock (40 MHz), also the USB interface clock.
- reset_n  in  1  asynchronous active-low reset.
- DaqData  in  16  DAQ word.
- DaqDataEnable  in  1  one-cycle write strobe for DaqData.
- FlushRequest  in  1  one-cycle pulse (e.g. OnceEnd/TestDone): drain and commit the packet.
- ClearOverflow  in  1  one-cycle pulse, clears Overflow.
- USB_FULL_N  in  1  USB FIFO full flag, low = full.
- USB_FD  out  16  USB FIFO data bus.
- USB_SLWR_N  out  1  USB write strobe, active low.
- USB_PKTEND_N  out  1  USB packet-end strobe, active low.
- BufferEmpty  out  1  internal buffer empty.
- FillLevel  out  ADDR_WIDTH+1  words currently buffered.
- Overflow  out  1  sticky: a DaqData word was dropped.
- FlushDone  out  1  one-cycle pulse when flush completes.
- WordsSent  out  32  count of words written to USB; wraps at 2^32.

Behaviour:
- Reset (async, reset_n low): USB_FD=0, USB_SLWR_N=1, USB_PKTEND_N=1, FlushDone=0, Overflow=0, WordsSent=0, FillLevel=0, BufferEmpty=1, FSM=IDLE. Pending flush and the "words since PKTEND" flag are cleared. Reset mid-transfer discards all buffered data.
- Buffer write:
  - On DaqDataEnable=1 with the buffer not full, the word is stored.
  - If the buffer is full, the word is dropped and Overflow is set on the next edge.
  - Overflow holds until ClearOverflow. If set and clear arrive in the same cycle, set wins.
- FillLevel:
  - Updated 1 cycle after the write/read.
  - A simultaneous buffer write and read leaves it unchanged.
  - Range 0..2^ADDR_WIDTH.
- All USB outputs are registered. Write issue rule: at edge t+1, USB_SLWR_N=0 and USB_FD=head word iff, at t:
  - FSM=WRITE,
  - the buffer is non-empty,
  - USB_FULL_N=1.
  This gives at most one word per cycle, back-to-back allowed. Each issued word increments WordsSent and sets the sent_since_pktend flag.
- FlushRequest: latched into flush_pending. A flush arriving while a flush is already pending merges into it (single PKTEND).
- FSM states and transitions:
  - IDLE -> WRITE when the buffer is non-empty or flush_pending.
  - WRITE -> FLUSH_WAIT when flush_pending and the buffer is empty. Otherwise stay in WRITE; return to IDLE when the buffer is empty and no flush is pending.
  - FLUSH_WAIT: one cycle so the last USB_SLWR_N strobe completes.
    - If sent_since_pktend or ALLOW_ZLP=1 -> PKTEND.
    - Else -> DONE, with no PKTEND.
  - PKTEND: USB_PKTEND_N=0 for exactly one cycle, issued only while USB_FULL_N=1. If full, wait in PKTEND with the strobe held high. Clear sent_since_pktend -> GAP.
  - GAP: PKTEND_GAP cycles with no SLWR or PKTEND -> DONE.
  - DONE: FlushDone=1 for one cycle, clear flush_pending -> IDLE.
- Data arriving during FLUSH_WAIT/PKTEND/GAP/DONE is buffered and not included in the committed packet; it is sent after returning to WRITE.
- USB_SLWR_N and USB_PKTEND_N are never low in the same cycle.
- USB_FULL_N going low stops issue from the next cycle. A word issued in the same cycle that FULL falls is counted as sent.

Decomposition:
- Shared package usb_if_pkg:
  - FSM state encoding: IDLE, WRITE, FLUSH_WAIT, PKTEND, GAP, DONE.
  - Word width constant 16.
  - Default PKTEND_GAP.
- Sub-module usb_tx_fifo: synchronous single-clock FIFO with first-word-fall-through head, full/empty and count outputs, parameterised by ADDR_WIDTH. The top holds the FSM, the counters and the overflow logic.

Test Plan:
- Reset release, then 8 words 0x0001..0x0008 with USB_FULL_N=1 -> 8 consecutive USB_SLWR_N low cycles in order, first strobe 2 cycles after the first enable. WordsSent=8, FillLevel returns to 0, USB_PKTEND_N stays high.
- 5 words, then FlushRequest -> 5 writes, then one USB_PKTEND_N low pulse, then 4 idle cycles, then a FlushDone pulse. A second FlushRequest with no new data and ALLOW_ZLP=0 -> no PKTEND, FlushDone still pulses.
- Hold USB_FULL_N=0, write 1030 words (ADDR_WIDTH=10) -> FillLevel=1024, Overflow=1, no SLWR strobes. Release FULL -> exactly 1024 words out, first 1024 values intact.
- Toggle USB_FULL_N every 3 cycles during a 100-word stream -> no strobe issued when FULL_N was 0 the previous cycle, no loss or duplication, WordsSent=100.
- FlushRequest while USB_FULL_N=0 at PKTEND -> PKTEND withheld until FULL_N=1. Pulse ClearOverflow together with a dropped write -> Overflow remains 1.
- Assert reset_n low mid-stream with 300 words buffered -> all outputs return to reset values asynchronously. After release, FillLevel=0 and the next word is the first one sent.
